// File: rtl/fp16_adder_pkg.sv
// fp16_adder_pkg: shared constants, operand/pipeline payload types and the
// FP16 unpack helper for the fp16_adder pipeline.
// Optional macro FP16_ADD_IEEE_SPECIALS_EN adds NaN/signed-Inf payload fields.
package fp16_adder_pkg;

  localparam int unsigned EXP_W    = 5;
  localparam int unsigned FRAC_W   = 10;
  localparam int unsigned MANT_W   = FRAC_W + 1;
  // {mant[10:0], guard, round, sticky}
  localparam int unsigned FIELD_W  = 14;
  localparam int unsigned EXP_BIAS = 15;
  localparam int unsigned EXP_MAX  = 31;
  localparam int unsigned LATENCY  = 3;

  localparam logic [15:0] INF_CODE  = 16'hFFFF;
  localparam logic [15:0] ZERO_CODE = 16'h0000;
`ifdef FP16_ADD_IEEE_SPECIALS_EN
  localparam logic [15:0] NAN_CODE  = 16'h7E00;
`endif

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              is_zero;
    logic              is_inf;
  } operand_t;

  // Stage 1 -> stage 2: larger operand A plus aligned B field.
  typedef struct packed {
    logic               sign;
    logic               eff_sub;
    logic [EXP_W-1:0]   exp;
    logic [MANT_W-1:0]  mant_a;
    logic [FIELD_W-1:0] field_b;
    logic               is_zero;
    logic               is_inf;
`ifdef FP16_ADD_IEEE_SPECIALS_EN
    logic               is_nan;
    logic               inf_sign;
`endif
  } s1_t;

  // Stage 2 -> stage 3: normalised field, leading one at bit FIELD_W-1.
  typedef struct packed {
    logic               sign;
    logic [EXP_W:0]     exp;
    logic [FIELD_W-1:0] norm;
    logic               is_zero;
    logic               is_inf;
`ifdef FP16_ADD_IEEE_SPECIALS_EN
    logic               is_nan;
    logic               inf_sign;
`endif
  } s2_t;

  // Subnormals (exp==0) flush to zero; exp==31 marks Inf (or NaN).
  function automatic operand_t unpack(input logic [15:0] x);
    operand_t o;
    o.sign    = x[15];
    o.exp     = x[14:10];
    o.is_zero = (x[14:10] == '0);
    o.is_inf  = (x[14:10] == 5'(EXP_MAX));
    o.mant    = o.is_zero ? '0 : {1'b1, x[9:0]};
    return o;
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// fp16_lzc: combinational leading-zero counter over the 14-bit normalise field.
// Ports: field (in, 14 bits), count (out, 4 bits; 14 when field is all zero).
// Optional macro FP16_ADD_IEEE_SPECIALS_EN: no effect here.
module fp16_lzc
  import fp16_adder_pkg::*;
(
  input  logic [FIELD_W-1:0] field,
  output logic [3:0]         count
);

  // Scan upward; the highest set bit writes last and wins.
  always_comb begin
    count = 4'(FIELD_W);
    for (int unsigned i = 0; i < FIELD_W; i++) begin
      if (field[i]) count = 4'(FIELD_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp16_adder.sv
// fp16_adder: 3-stage pipelined FP16 adder (unpack/align, add/normalise,
// round/pack). Subnormals flush to zero.
// Ports: clk, rst (async, active-low), input_valid, data1, data2 (FP16 in),
//        data_o (registered sum, holds between results), output_update (pulse).
// Optional macro FP16_ADD_IEEE_SPECIALS_EN: IEEE signed Inf and NaN results;
// otherwise any Inf/overflow gives 16'hFFFF.
module fp16_adder
  import fp16_adder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        input_valid,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [15:0] data_o,
  output logic        output_update
);

  logic [LATENCY-1:0] vld;
  s1_t p1, s1_d;
  s2_t p2, s2_d;
  logic [15:0] result;

  // Stage 1: unpack, order by magnitude, align B
  operand_t op1, op2, a, b;
  logic               swap;
  logic [EXP_W-1:0]   diff;
  logic [FIELD_W-1:0] full_b, shifted, lost_mask;

  always_comb begin
    op1       = unpack(data1);
    op2       = unpack(data2);
    swap      = data2[14:0] > data1[14:0];
    a         = swap ? op2 : op1;
    b         = swap ? op1 : op2;
    diff      = a.exp - b.exp;
    full_b    = {b.mant, 3'b000};
    shifted   = full_b >> diff;
    lost_mask = ~({FIELD_W{1'b1}} << diff);

    s1_d         = '0;
    s1_d.sign    = a.sign;
    s1_d.eff_sub = a.sign ^ b.sign;
    s1_d.exp     = a.exp;
    s1_d.mant_a  = a.mant;
    s1_d.is_zero = a.is_zero;
    s1_d.is_inf  = a.is_inf | b.is_inf;
    if (diff >= 5'(FIELD_W))
      s1_d.field_b = {{(FIELD_W-1){1'b0}}, |b.mant};
    else
      s1_d.field_b = {shifted[FIELD_W-1:1], shifted[0] | (|(full_b & lost_mask))};
`ifdef FP16_ADD_IEEE_SPECIALS_EN
    s1_d.is_nan   = (op1.is_inf & (|data1[9:0])) | (op2.is_inf & (|data2[9:0]))
                  | (op1.is_inf & op2.is_inf & (op1.sign ^ op2.sign));
    s1_d.inf_sign = op1.is_inf ? op1.sign : op2.sign;
`endif
  end

  // Stage 2: add/subtract, normalise
  logic [FIELD_W:0] ma, mb, sum;
  logic [3:0]       lz;

  fp16_lzc u_lzc (
    .field (sum[FIELD_W-1:0]),
    .count (lz)
  );

  always_comb begin
    ma  = {1'b0, p1.mant_a, 3'b000};
    mb  = {1'b0, p1.field_b};
    sum = p1.eff_sub ? (ma - mb) : (ma + mb);

    s2_d         = '0;
    s2_d.sign    = p1.sign;
    s2_d.is_inf  = p1.is_inf;
    s2_d.is_zero = p1.is_zero;
`ifdef FP16_ADD_IEEE_SPECIALS_EN
    s2_d.is_nan   = p1.is_nan;
    s2_d.inf_sign = p1.inf_sign;
`endif
    if (sum == '0) begin
      s2_d.is_zero = 1'b1;
    end else if (sum[FIELD_W]) begin
      // Carry out: shift right, folding the dropped bit into sticky.
      s2_d.norm = {sum[FIELD_W:2], sum[1] | sum[0]};
      s2_d.exp  = {1'b0, p1.exp} + 6'd1;
    end else begin
      s2_d.norm = sum[FIELD_W-1:0] << lz;
      s2_d.exp  = {1'b0, p1.exp} - {2'b00, lz};
      if ({1'b0, lz} >= p1.exp) s2_d.is_zero = 1'b1;
    end
  end

  // Stage 3: round to nearest even, pack
  logic [MANT_W-1:0] mant;
  logic              rnd;
  logic [MANT_W:0]   mr;
  logic [EXP_W:0]    exp_f;
  logic [FRAC_W-1:0] frac;

  always_comb begin
    mant  = p2.norm[FIELD_W-1:3];
    rnd   = p2.norm[2] & (p2.norm[1] | p2.norm[0] | mant[0]);
    mr    = {1'b0, mant} + {{MANT_W{1'b0}}, rnd};
    exp_f = p2.exp + {{EXP_W{1'b0}}, mr[MANT_W]};
    frac  = mr[MANT_W] ? mr[FRAC_W:1] : mr[FRAC_W-1:0];
`ifdef FP16_ADD_IEEE_SPECIALS_EN
    if (p2.is_nan)                   result = NAN_CODE;
    else if (p2.is_inf)              result = {p2.inf_sign, 15'h7C00};
    else if (p2.is_zero)             result = ZERO_CODE;
    else if (exp_f >= 6'(EXP_MAX))   result = {p2.sign, 15'h7C00};
    else                             result = {p2.sign, exp_f[EXP_W-1:0], frac};
`else
    if (p2.is_inf)                   result = INF_CODE;
    else if (p2.is_zero)             result = ZERO_CODE;
    else if (exp_f >= 6'(EXP_MAX))   result = INF_CODE;
    else                             result = {p2.sign, exp_f[EXP_W-1:0], frac};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= '0;
      p1     <= '0;
      p2     <= '0;
      data_o <= '0;
    end else begin
      vld <= {vld[LATENCY-2:0], input_valid};
      p1  <= s1_d;
      p2  <= s2_d;
      if (vld[LATENCY-2]) data_o <= result;
    end
  end

  assign output_update = vld[LATENCY-1];

endmodule

// File: tb/tb_fp16_adder.sv
// tb_fp16_adder: directed-vector bench for fp16_adder (default build).
module tb_fp16_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        input_valid = 1'b0;
  logic [15:0] data1 = '0;
  logic [15:0] data2 = '0;
  logic [15:0] data_o;
  logic        output_update;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fp16_adder dut (
    .clk           (clk),
    .rst           (rst),
    .input_valid   (input_valid),
    .data1         (data1),
    .data2         (data2),
    .data_o        (data_o),
    .output_update (output_update)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back('{16'h5BF0, 16'h47AF, 16'h5C17, "add_254_7p68"});
    vecs.push_back('{16'h47AF, 16'h5BF0, 16'h5C17, "add_swapped"});
    vecs.push_back('{16'h5BF0, 16'hDBF1, 16'hB000, "sub_neg_0p125"});
    vecs.push_back('{16'h0000, 16'h47AF, 16'h47AF, "zero_plus_x"});
    vecs.push_back('{16'h47AF, 16'h0000, 16'h47AF, "x_plus_zero"});
    vecs.push_back('{16'h0000, 16'h0000, 16'h0000, "zero_plus_zero"});
    vecs.push_back('{16'h7BFF, 16'h0400, 16'h7BFF, "max_plus_min"});
    vecs.push_back('{16'h7BFF, 16'h8400, 16'h7BFF, "max_minus_min"});
    vecs.push_back('{16'h0400, 16'h8400, 16'h0000, "exact_cancel"});
    vecs.push_back('{16'hFFFF, 16'h5BF0, 16'hFFFF, "inf_a"});
    vecs.push_back('{16'h0000, 16'hFFFF, 16'hFFFF, "inf_b"});
    vecs.push_back('{16'h7C00, 16'h3C00, 16'hFFFF, "pos_inf_code"});
    vecs.push_back('{16'h7BFF, 16'h7BFF, 16'hFFFF, "overflow"});
    vecs.push_back('{16'h3C00, 16'h3C00, 16'h4000, "one_plus_one"});
    vecs.push_back('{16'h3C00, 16'h1000, 16'h3C00, "tie_to_even_down"});
    vecs.push_back('{16'h3C01, 16'h1000, 16'h3C02, "tie_to_even_up"});
    vecs.push_back('{16'h0001, 16'h3C00, 16'h3C00, "subnormal_flush"});
    vecs.push_back('{16'h0401, 16'h8400, 16'h0000, "underflow_zero"});

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk("reset_data", data_o, 16'h0000);
    chk("reset_update", {15'b0, output_update}, 16'h0001 & 16'h0000);
    rst = 1'b1;
    tick();

    // Isolated vectors: exact 3-cycle latency, single pulse, hold afterwards
    for (int i = 0; i < vecs.size(); i++) begin
      data1 = vecs[i].a;
      data2 = vecs[i].b;
      input_valid = 1'b1;
      tick();
      input_valid = 1'b0;
      data1 = 16'h1234;
      data2 = 16'h4321;
      tick();
      chk({vecs[i].name, "_early"}, {15'b0, output_update}, 16'h0000);
      tick();
      chk({vecs[i].name, "_update"}, {15'b0, output_update}, 16'h0001);
      chk(vecs[i].name, data_o, vecs[i].sum);
      tick();
      chk({vecs[i].name, "_pulse_end"}, {15'b0, output_update}, 16'h0000);
      chk({vecs[i].name, "_hold"}, data_o, vecs[i].sum);
    end

    // Back-to-back: swapped pair on consecutive cycles
    data1 = 16'h5BF0; data2 = 16'h47AF; input_valid = 1'b1;
    tick();
    data1 = 16'h47AF; data2 = 16'h5BF0;
    tick();
    input_valid = 1'b0;
    tick();
    chk("b2b_first_update", {15'b0, output_update}, 16'h0001);
    chk("b2b_first_data", data_o, 16'h5C17);
    tick();
    chk("b2b_second_update", {15'b0, output_update}, 16'h0001);
    chk("b2b_second_data", data_o, 16'h5C17);
    tick();
    chk("b2b_done_update", {15'b0, output_update}, 16'h0000);

    // Back-to-back with different results, then bubbles hold data_o
    data1 = 16'h3C00; data2 = 16'h3C00; input_valid = 1'b1;
    tick();
    data1 = 16'h5BF0; data2 = 16'hDBF1;
    tick();
    input_valid = 1'b0;
    tick();
    chk("pipe_a_data", data_o, 16'h4000);
    tick();
    chk("pipe_b_update", {15'b0, output_update}, 16'h0001);
    chk("pipe_b_data", data_o, 16'hB000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bubble_hold", data_o, 16'hB000);
      chk("bubble_no_update", {15'b0, output_update}, 16'h0000);
    end

    // Reset with two operations in flight
    data1 = 16'h5BF0; data2 = 16'h47AF; input_valid = 1'b1;
    tick();
    data1 = 16'h3C00; data2 = 16'h3C00;
    tick();
    input_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("midrst_data", data_o, 16'h0000);
    chk("midrst_update", {15'b0, output_update}, 16'h0000);
    tick();
    #2 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_no_update", {15'b0, output_update}, 16'h0000);
      chk("post_rst_data", data_o, 16'h0000);
    end

    // Recovery after reset
    data1 = 16'h3C00; data2 = 16'h3C00; input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    tick();
    tick();
    chk("recover_update", {15'b0, output_update}, 16'h0001);
    chk("recover_data", data_o, 16'h4000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
